// File: rtl/div8_ctrl_pkg.sv
// Shared definitions for the 8-bit restoring divider controller and its bench.
package div8_ctrl_pkg;

    // Controller states; the encodings are fixed so that any block reading
    // them agrees with the controller.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // One restoring step per dividend bit.
    localparam int ITER = 8;

    // Counter value of the final restoring step.
    localparam logic [2:0] LAST_CNT = 3'(ITER - 1);

    // Quotient reported for a division by zero.
    localparam logic [7:0] DZ_QUOTIENT = 8'hFF;

endpackage

// File: rtl/div8_addsub.sv
// Shared 8-bit adder/subtractor: m_i=0 gives a+b, m_i=1 gives a-b.
// c_o is the carry out; when subtracting, c_o=1 means no borrow.
module div8_addsub (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       m_i,
    output logic [7:0] s_o,
    output logic       c_o,
    output logic       v_o,
    output logic       n_o,
    output logic       z_o
);

    logic [7:0] b_eff;

    // Two's-complement subtract is a + ~b + 1.
    assign b_eff        = b_i ^ {8{m_i}};
    assign {c_o, s_o}   = 9'(a_i) + 9'(b_eff) + 9'(m_i);
    assign v_o          = (a_i[7] == b_eff[7]) && (s_o[7] != a_i[7]);
    assign n_o          = s_o[7];
    assign z_o          = (s_o == 8'd0);

endmodule

// File: rtl/div8_ctrl.sv
// 8-bit unsigned restoring divider: one quotient bit per cycle, MSB first,
// using the shared addsub unit as the only subtractor.
module div8_ctrl
    import div8_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [7:0] divisor,
    output logic       busy,
    output logic       done,
    output logic [7:0] quotient,
    output logic [7:0] remainder,
    output logic       dz_err
);

    state_e     state_q;
    logic [2:0] count_q;
    logic [7:0] dvd_q;
    logic [7:0] dvs_q;
    logic [7:0] rem_q;
    logic [7:0] quo_q;
    logic       dz_q;
    logic       busy_q;
    logic       done_q;

    logic [8:0] shifted;
    logic       take;
    logic [7:0] rem_step;

    logic [7:0] as_s;
    logic       as_c;
    logic       addsub_v_unused;
    logic       addsub_n_unused;
    logic       addsub_z_unused;

    // Trial subtraction of the divisor from the low byte of the shifted remainder.
    div8_addsub u_addsub (
        .a_i (shifted[7:0]),
        .b_i (dvs_q),
        .m_i (1'b1),
        .s_o (as_s),
        .c_o (as_c),
        .v_o (addsub_v_unused),
        .n_o (addsub_n_unused),
        .z_o (addsub_z_unused)
    );

    // One restoring step: bring down the next dividend bit and decide whether
    // the divisor fits. Bit 8 set means the value is at least 256 and so always
    // exceeds the divisor, even though the 8-bit subtract reports a borrow.
    // NOTE: every always_comb output gets a value on every path so no latch is inferred.
    always_comb begin
        shifted  = {rem_q, dvd_q[LAST_CNT - count_q]};
        take     = shifted[8] | as_c;
        rem_step = take ? as_s : shifted[7:0];
    end

    // Controller FSM with registered status and result outputs.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= 3'd0;
            dvd_q   <= 8'd0;
            dvs_q   <= 8'd0;
            rem_q   <= 8'd0;
            quo_q   <= 8'd0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        dvd_q <= dividend;
                        dvs_q <= divisor;
                        if (divisor != 8'd0) begin
                            rem_q   <= 8'd0;
                            quo_q   <= 8'd0;
                            dz_q    <= 1'b0;
                            count_q <= 3'd0;
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end else begin
                            rem_q   <= dividend;
                            quo_q   <= DZ_QUOTIENT;
                            dz_q    <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                RUN: begin
                    rem_q   <= rem_step;
                    quo_q   <= {quo_q[6:0], take};
                    count_q <= count_q + 3'd1;
                    if (count_q == LAST_CNT) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign dz_err    = dz_q;

endmodule

// File: tb/tb_div8_ctrl.sv
// Self-checking bench for div8_ctrl: directed table, multi-cycle corner
// sequences, and random operands against an arithmetic reference model.
module tb_div8_ctrl;
    import div8_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       dz_err;

    int n_vec  = 0;
    int n_fail = 0;

    div8_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dz_err    (dz_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] dvd;
        logic [7:0] dvs;
        int         inject;   // observation cycle at which a stray 50/5 start is driven, -1 = none
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        int         lat;      // cycles from the start cycle to the done cycle
    } vec_t;

    task automatic check(input string name, input int actual, input int expected);
        n_vec++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference model straight from the arithmetic definition of division.
    task automatic model(input logic [7:0] dvd, input logic [7:0] dvs,
                         output logic [7:0] q, output logic [7:0] r,
                         output logic dz, output int lat);
        if (dvs == 8'd0) begin
            q = 8'hFF; r = dvd; dz = 1'b1; lat = 1;
        end else begin
            q = dvd / dvs; r = dvd % dvs; dz = 1'b0; lat = ITER + 1;
        end
    endtask

    // Issue one division and watch 14 cycles: results at done, latency,
    // pulse count, busy occupancy and busy/done overlap. Operand inputs are
    // scrambled while the division runs.
    task automatic run_div(input string tag, input logic [7:0] dvd, input logic [7:0] dvs,
                           input int inject, input logic [7:0] eq, input logic [7:0] er,
                           input logic edz, input int elat);
        int ndone = 0, nbusy = 0, overlap = 0, lat = -1;
        logic [7:0] q = 8'd0, r = 8'd0;
        logic dz = 1'b0;
        @(negedge clk);
        dividend = dvd; divisor = dvs; start = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (done) begin
                if (ndone == 0) begin
                    q = quotient; r = remainder; dz = dz_err; lat = k;
                end
                ndone++;
            end
            if (busy) nbusy++;
            if (busy && done) overlap++;
            if (k == inject) begin
                start = 1'b1; dividend = 8'd50; divisor = 8'd5;
            end else begin
                start = 1'b0; dividend = 8'($urandom); divisor = 8'($urandom);
            end
        end
        check({tag, "_quotient"}, int'(q), int'(eq));
        check({tag, "_remainder"}, int'(r), int'(er));
        check({tag, "_dz_err"}, int'(dz), int'(edz));
        check({tag, "_latency"}, lat, elat);
        check({tag, "_done_pulses"}, ndone, 1);
        check({tag, "_busy_cycles"}, nbusy, edz ? 0 : ITER);
        check({tag, "_busy_done_overlap"}, overlap, 0);
    endtask

    vec_t tbl[8];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{dvd: 8'd100, dvs: 8'd7,   inject: -1, q: 8'd14,  r: 8'd2,   dz: 1'b0, lat: 9};
        tbl[1] = '{dvd: 8'd255, dvs: 8'd255, inject: -1, q: 8'd1,   r: 8'd0,   dz: 1'b0, lat: 9};
        tbl[2] = '{dvd: 8'd255, dvs: 8'd1,   inject: -1, q: 8'd255, r: 8'd0,   dz: 1'b0, lat: 9};
        tbl[3] = '{dvd: 8'd5,   dvs: 8'd9,   inject: -1, q: 8'd0,   r: 8'd5,   dz: 1'b0, lat: 9};
        tbl[4] = '{dvd: 8'd200, dvs: 8'd0,   inject: -1, q: 8'hFF,  r: 8'd200, dz: 1'b1, lat: 1};
        tbl[5] = '{dvd: 8'd100, dvs: 8'd7,   inject: 3,  q: 8'd14,  r: 8'd2,   dz: 1'b0, lat: 9};
        tbl[6] = '{dvd: 8'd100, dvs: 8'd7,   inject: 9,  q: 8'd14,  r: 8'd2,   dz: 1'b0, lat: 9};
        tbl[7] = '{dvd: 8'd200, dvs: 8'd129, inject: -1, q: 8'd1,   r: 8'd71,  dz: 1'b0, lat: 9};

        rst = 1'b1; start = 1'b0; dividend = 8'd0; divisor = 8'd0;
        repeat (2) @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_quotient", int'(quotient), 0);
        check("reset_remainder", int'(remainder), 0);
        check("reset_dz_err", int'(dz_err), 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            run_div($sformatf("tbl%0d", i), tbl[i].dvd, tbl[i].dvs, tbl[i].inject,
                    tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].lat);

        // Abort 100/7 with reset during the fourth RUN cycle.
        begin
            int nd = 0;
            @(negedge clk);
            dividend = 8'd100; divisor = 8'd7; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (3) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            check("abort_busy", int'(busy), 0);
            check("abort_done", int'(done), 0);
            check("abort_quotient", int'(quotient), 0);
            check("abort_remainder", int'(remainder), 0);
            check("abort_dz_err", int'(dz_err), 0);
            rst = 1'b0;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                if (done) nd++;
            end
            check("abort_no_done", nd, 0);
            run_div("after_abort", 8'd9, 8'd3, -1, 8'd3, 8'd0, 1'b0, 9);
        end

        // Random operands, about one in eight with a zero divisor.
        for (int i = 0; i < 40; i++) begin
            logic [7:0] a, b, eq, er;
            logic edz;
            int elat;
            a = 8'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            model(a, b, eq, er, edz, elat);
            run_div($sformatf("rnd%0d_%0d_div_%0d", i, a, b), a, b, -1, eq, er, edz, elat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/div8_ctrl.md
DIV8_CTRL -- requirements
Module: div8_ctrl

Interface
REQ-001 Parameters: none; operand width is fixed at 8 bits to match the shared addsub unit.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a division; sampled only in IDLE.
REQ-006 dividend  input  8  unsigned dividend, captured on an accepted start.
REQ-007 divisor  input  8  unsigned divisor, captured on an accepted start.
REQ-008 busy  output  1  high while a division is in progress (RUN state).
REQ-009 done  output  1  one-cycle pulse when results become valid.
REQ-010 quotient  output  8  unsigned quotient, held until the next accepted start.
REQ-011 remainder  output  8  unsigned remainder, held until the next accepted start.
REQ-012 dz_err  output  1  divide-by-zero flag, held until the next accepted start.

Function
REQ-013 The FSM SHALL have exactly these states: IDLE, RUN, DONE.
REQ-014 IDLE: start=1 with divisor!=0 SHALL capture the operands, clear the partial remainder and the quotient, set the iteration counter to 0, and go to RUN.
REQ-015 IDLE: start=1 with divisor==0 SHALL go directly to DONE with dz_err=1, quotient=8'hFF, remainder=dividend.
REQ-016 RUN: each cycle SHALL perform one restoring step, MSB first:
- form the 9-bit shifted value {R, dividend bit};
- drive the addsub unit with M=1 (subtract), A = low 8 bits of the shifted value, B = divisor;
- take = shifted bit 8 OR addsub carry-out (carry=1 means no borrow).
REQ-017 When take=1, R SHALL become the addsub difference S and the quotient bit SHALL be 1; otherwise R SHALL become the low 8 bits of the shifted value and the quotient bit SHALL be 0.
REQ-018 RUN SHALL last exactly 8 cycles (3-bit counter 0..7); after the step with count 7 the FSM SHALL go to DONE.
REQ-019 DONE: done=1 for exactly one cycle; quotient, remainder and dz_err SHALL be valid in that cycle; the next state SHALL be IDLE.
REQ-020 Latency: a start accepted at edge N SHALL produce done=1 in the cycle after edge N+9 (divisor==0: after edge N+1).
REQ-021 start SHALL be ignored while in RUN or DONE; there is no queueing.
REQ-022 busy SHALL be 1 only in RUN; done and busy SHALL never be high together.
REQ-023 The addsub V, N and Z outputs SHALL be left unused; only S and C are consumed.
REQ-024 The operand registers SHALL be stable through RUN, independent of input changes after capture.

Reset
REQ-025 On rst=1 at a clock edge the FSM SHALL enter IDLE, and busy, done, quotient, remainder, dz_err and the counter SHALL all become 0.
REQ-026 Reset SHALL take priority over start, and SHALL abort a division in progress without producing a done pulse.

Structure
REQ-027 The state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the constant ITER=8 SHALL live in a shared include/package file used by the controller and the bench.
REQ-028 Exactly one sub-module SHALL be instantiated: the existing 8-bit addsub unit, which is the only subtractor in the datapath.
REQ-029 All outputs SHALL be driven from registers.

Verification
REQ-030 Basic division: 100/7 -> done 9 cycles after start, quotient=14, remainder=2, dz_err=0.
REQ-031 Bit-8 and carry path: 255/255 -> quotient=1, remainder=0; 255/1 -> quotient=255, remainder=0.
REQ-032 Dividend smaller than divisor: 5/9 -> quotient=0, remainder=5.
REQ-033 Divide by zero: 200/0 -> done 1 cycle after start, dz_err=1, quotient=8'hFF, remainder=200, busy never high.
REQ-034 Busy protection: a second start of 50/5 during RUN of 100/7 -> ignored; results stay 14/2 and exactly one done pulse is produced.
REQ-035 Abort: rst at RUN cycle 4 -> all outputs 0 next cycle, no done pulse; a following 9/3 -> quotient=3, remainder=0.
